// File: rtl/seq_csel_subtractor.sv
// Multi-cycle carry-select subtractor: diff = a - b - bin, one SEG-bit segment per clock.
// Each segment computes both borrow-in candidates; the registered borrow picks one.
module seq_csel_subtractor #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSEG  = WIDTH / SEG;
  localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NSEG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Segment views of the latched operands, indexed by the running segment counter.
  logic [SEG-1:0] a_segs [NSEG];
  logic [SEG-1:0] b_segs [NSEG];

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      assign a_segs[gi] = a_q[gi*SEG +: SEG];
      assign b_segs[gi] = b_q[gi*SEG +: SEG];
    end
  endgenerate

  logic [SEG-1:0] a_k, b_k;
  logic [SEG:0]   cand0, cand1, sel;

  always_comb begin
    a_k   = a_segs[seg_q];
    b_k   = b_segs[seg_q];
    // The extra MSB of each candidate is the borrow out of this segment.
    cand0 = {1'b0, a_k} - {1'b0, b_k};
    cand1 = {1'b0, a_k} - {1'b0, b_k} - {{SEG{1'b0}}, 1'b1};
    sel   = borrow_q ? cand1 : cand0;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    seg_d    = seg_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          bin_load();
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NSEG; i++) begin
          if (seg_q == SEG_W'(i)) work_d[i*SEG +: SEG] = sel[SEG-1:0];
        end
        borrow_d = sel[SEG];
        if (seg_q == LAST_SEG) state_d = S_DONE;
        else                   seg_d   = seg_q + 1'b1;
      end
      S_DONE: begin
        diff_d  = work_q;
        bout_d  = borrow_q;
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_q[WIDTH-1] != a_q[WIDTH-1]);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accept-time initialisation of the working registers.
  function automatic void bin_load();
    seg_d    = '0;
    work_d   = '0;
    borrow_d = bin;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      seg_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      seg_q    <= seg_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_csel_subtractor.sv
// Scoreboard bench for seq_csel_subtractor: expected results are queued at start and
// popped when done pulses; protocol and reset scenarios run as separate tasks.
module tb_seq_csel_subtractor;

  localparam int WIDTH = 32;
  localparam int SEG   = 8;
  localparam int NSEG  = WIDTH / SEG;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy, done, bout, ovf;
  logic [WIDTH-1:0] diff;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  seq_csel_subtractor #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mbin);
    exp_t        e;
    logic [WIDTH:0] full;
    full   = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
    e.diff = full[WIDTH-1:0];
    e.bout = full[WIDTH];
    e.ovf  = (ma[WIDTH-1] != mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    return e;
  endfunction

  // Drives one operation from the current time (just after an edge). With noise set,
  // start is held high with junk operands throughout RUN and DONE.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tbin, input bit noise, input bit check_tail,
                        input string name);
    exp_t             got, e;
    int               cycles;
    logic [WIDTH-1:0] held;
    bit               partial;
    sb_q.push_back(model(ta, tb_, tbin));
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    held = diff; partial = 0; cycles = 0;
    start = noise;
    total++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_accept got=%b want=1", name, busy);
    else passed++;
    while (done !== 1'b1 && cycles < 20) begin
      if (noise) begin
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cycles++;
      if (done !== 1'b1 && diff !== held) partial = 1;
      if (cycles == NSEG + 1) start = 1'b0;
    end
    start = 1'b0;
    total++;
    if (cycles !== NSEG + 1) $display("FAIL %s latency got=%0d want=%0d", name, cycles, NSEG + 1);
    else passed++;
    total++;
    if (partial) $display("FAIL %s partial_result diff changed before done", name);
    else passed++;
    e   = sb_q.pop_front();
    got = '{diff: diff, bout: bout, ovf: ovf};
    total++;
    if (got !== e)
      $display("FAIL %s result got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
               name, got.diff, got.bout, got.ovf, e.diff, e.bout, e.ovf);
    else passed++;
    $display("op %s a=%h b=%h bin=%b -> diff=%h bout=%b ovf=%b (%0d cycles)",
             name, ta, tb_, tbin, diff, bout, ovf, cycles);
    if (check_tail) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== e.diff)
        $display("FAIL %s tail got done=%b busy=%b diff=%h want done=0 busy=0 diff=%h",
                 name, done, busy, diff, e.diff);
      else passed++;
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy, done, bout, ovf, diff} !== '0)
      $display("FAIL reset_state got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
               busy, done, diff, bout, ovf);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(32'h00000005, 32'h00000003, 1'b0, 0, 1, "basic");
  endtask

  task automatic test_ripple();
    run_op(32'h00000100, 32'h00000001, 1'b0, 0, 1, "ripple_100");
    run_op(32'h00000000, 32'h00000001, 1'b0, 0, 1, "ripple_wrap");
  endtask

  task automatic test_overflow();
    run_op(32'h80000000, 32'h00000001, 1'b0, 0, 1, "ovf_neg");
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1, "ovf_pos");
  endtask

  task automatic test_borrow_in();
    run_op(32'h00000010, 32'h00000010, 1'b1, 0, 1, "bin");
  endtask

  task automatic test_protocol();
    run_op(32'h12345678, 32'h01020304, 1'b0, 1, 1, "ignored_starts");
  endtask

  task automatic test_back_to_back();
    run_op(32'hDEADBEEF, 32'h0000FFFF, 1'b1, 0, 0, "b2b_first");
    run_op(32'h00000001, 32'h00000002, 1'b0, 0, 1, "b2b_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1, "random");
    end
  endtask

  task automatic test_reset_mid_run();
    int late_done;
    a = 32'h00000007; b = 32'h00000009; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, bout, ovf, diff} !== '0)
      $display("FAIL reset_mid_run got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
               busy, done, diff, bout, ovf);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    late_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) late_done++;
    end
    total++;
    if (late_done !== 0) $display("FAIL reset_no_done got=%0d active cycles want=0", late_done);
    else passed++;
    run_op(32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 0, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_overflow();
    test_borrow_in();
    test_protocol();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    total++;
    if (sb_q.size() !== 0) $display("FAIL scoreboard_empty got=%0d want=0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
